tick_gen: RTL and testbench

Parametrised, multi-rate programmable tick generator. It is the next generation of the team's switch-selected counter/valid pulse block.
- Adds a runtime-programmable period, one-shot mode and a glitch-free rate change.
- Outputs a square-wave level and a running tick count.
- Drives the shift-register datapath and LED stages as their timebase.

---
 rtl/tick_gen_pkg.sv | 19 +
 rtl/tick_gen_rate_table.sv | 23 ++
 rtl/tick_gen.sv | 110 +++++++++++
 tb/tb_tick_gen.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared types and constants for the programmable tick generator.
package tick_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int MODE_ONESHOT = 0;
  localparam int MODE_CUSTOM  = 1;

  // Terminal count of rate k: each step down the table halves the period.
  function automatic logic [63:0] rate_limit(input int nb_counter, input int shift_base,
                                             input int k);
    return (64'd1 << (nb_counter - shift_base - k)) - 64'd1;
  endfunction

endpackage

// File: rtl/tick_gen_rate_table.sv
// Rate table: maps i_sel to a fixed terminal count, all entries are elaboration constants.
module tick_rate_table
  import tick_gen_pkg::*;
#(
  parameter int NB_COUNTER = 32,
  parameter int NB_SEL     = 2,
  parameter int SHIFT_BASE = 10
) (
  input  logic [NB_SEL-1:0]     i_sel,
  output logic [NB_COUNTER-1:0] o_limit
);

  localparam int NUM_RATES = 2 ** NB_SEL;

  logic [NUM_RATES-1:0][NB_COUNTER-1:0] rates;

  for (genvar k = 0; k < NUM_RATES; k++) begin : g_rate
    assign rates[k] = NB_COUNTER'(rate_limit(NB_COUNTER, SHIFT_BASE, k));
  end

  assign o_limit = rates[i_sel];

endmodule

// File: rtl/tick_gen.sv
// Multi-rate tick generator: free-run or one-shot, table or custom period,
// with the period limit shadowed so rate changes only land on a period boundary.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NB_COUNTER = 32,
  parameter int NB_SEL     = 2,
  parameter int SHIFT_BASE = 10,
  parameter int NB_TICKS   = 8
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [NB_SEL-1:0]     i_sel,
  input  logic [1:0]            i_mode,
  input  logic [NB_COUNTER-1:0] i_period,
  output logic                  o_tick,
  output logic                  o_level,
  output logic                  o_busy,
  output logic [NB_TICKS-1:0]   o_tick_count
);

  localparam logic [NB_COUNTER-1:0] LIMIT_RST =
    NB_COUNTER'(rate_limit(NB_COUNTER, SHIFT_BASE, 0));

  state_e                state_q, state_d;
  logic [NB_COUNTER-1:0] cnt_q, cnt_d;
  logic [NB_COUNTER-1:0] limit_q, limit_d;
  logic                  tick_q, tick_d;
  logic                  level_q, level_d;
  logic [NB_TICKS-1:0]   tcnt_q, tcnt_d;

  logic [NB_COUNTER-1:0] tbl_limit;
  logic [NB_COUNTER-1:0] sel_limit;

  tick_rate_table #(
    .NB_COUNTER (NB_COUNTER),
    .NB_SEL     (NB_SEL),
    .SHIFT_BASE (SHIFT_BASE)
  ) u_rate_table (
    .i_sel   (i_sel),
    .o_limit (tbl_limit)
  );

  assign sel_limit = i_mode[MODE_CUSTOM] ? i_period : tbl_limit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    tick_d  = 1'b0;
    level_d = level_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        limit_d = sel_limit;
        cnt_d   = '0;
        if (i_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == limit_q) begin
          // Period boundary: the only point where a new limit may take effect.
          cnt_d   = '0;
          tick_d  = 1'b1;
          level_d = ~level_q;
          tcnt_d  = tcnt_q + NB_TICKS'(1);
          limit_d = sel_limit;
          if (i_mode[MODE_ONESHOT]) state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + NB_COUNTER'(1);
        end
      end
      ST_DONE: begin
        cnt_d = '0;
        if (!i_enable) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      limit_q <= LIMIT_RST;
      tick_q  <= 1'b0;
      level_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign o_tick       = tick_q;
  assign o_level      = level_q;
  assign o_busy       = (state_q == ST_RUN);
  assign o_tick_count = tcnt_q;

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: directed scenarios plus randomized traffic
// compared against a countdown-style behavioural model.
module tb_tick_gen;

  localparam int NB_COUNTER = 16;
  localparam int NB_SEL     = 2;
  localparam int SHIFT_BASE = 10;
  localparam int NB_TICKS   = 8;

  logic                  clock = 1'b0;
  logic                  i_reset;
  logic                  i_enable;
  logic [NB_SEL-1:0]     i_sel;
  logic [1:0]            i_mode;
  logic [NB_COUNTER-1:0] i_period;
  logic                  o_tick;
  logic                  o_level;
  logic                  o_busy;
  logic [NB_TICKS-1:0]   o_tick_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: period in cycles, countdown to the next tick.
  int   tbl[4] = '{63, 31, 15, 7};
  logic m_run, m_done, m_tick, m_level;
  logic [NB_TICKS-1:0] m_count;
  int   m_period, m_remain;

  tick_gen #(
    .NB_COUNTER (NB_COUNTER),
    .NB_SEL     (NB_SEL),
    .SHIFT_BASE (SHIFT_BASE),
    .NB_TICKS   (NB_TICKS)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_sel        (i_sel),
    .i_mode       (i_mode),
    .i_period     (i_period),
    .o_tick       (o_tick),
    .o_level      (o_level),
    .o_busy       (o_busy),
    .o_tick_count (o_tick_count)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_run = 0; m_done = 0; m_tick = 0; m_level = 0; m_count = '0;
    m_period = tbl[0] + 1; m_remain = 0;
  endtask

  task automatic model_step();
    int lsel;
    lsel = i_mode[1] ? int'(i_period) : tbl[i_sel];
    m_tick = 0;
    if (i_reset) begin
      model_reset();
    end else if (m_run) begin
      if (!i_enable) m_run = 0;
      else begin
        m_remain = m_remain - 1;
        if (m_remain == 0) begin
          m_tick = 1; m_level = ~m_level; m_count = m_count + 1'b1;
          m_period = lsel + 1; m_remain = m_period;
          if (i_mode[0]) begin m_run = 0; m_done = 1; end
        end
      end
    end else if (m_done) begin
      if (!i_enable) m_done = 0;
    end else begin
      m_period = lsel + 1;
      if (i_enable) begin m_run = 1; m_remain = m_period; end
    end
  endtask

  // One active edge, model advanced with the inputs sampled at that edge.
  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    i_reset = 1'b1; i_enable = 1'b0; i_sel = '0; i_mode = 2'b00; i_period = '0;
    model_reset();
    repeat (2) @(negedge clock);
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_chk++;
    if ({o_tick, o_level, o_busy, o_tick_count} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_state: got tick=%b lvl=%b busy=%b cnt=%0d, want all 0",
               o_tick, o_level, o_busy, o_tick_count);
    end
  endtask

  task automatic test_first_ticks();
    logic [2:0] lvl_exp = 3'b101;
    apply_reset();
    i_sel = 2'd3; i_enable = 1'b1;
    for (int k = 0; k <= 25; k++) begin
      cyc();
      n_chk++;
      if ({o_tick, o_level, o_busy, o_tick_count} !== {m_tick, m_level, m_run, m_count}) begin
        n_fail++;
        $display("FAIL first_ticks_model E%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", k,
                 o_tick, o_level, o_busy, o_tick_count, m_tick, m_level, m_run, m_count);
      end
      if (k == 8 || k == 16 || k == 24) begin
        n_chk++;
        if (o_tick !== 1'b1 || o_level !== lvl_exp[k/8-1] || o_tick_count !== 8'(k/8)) begin
          n_fail++;
          $display("FAIL first_ticks_E%0d: got tick=%b lvl=%b cnt=%0d want 1/%b/%0d", k,
                   o_tick, o_level, o_tick_count, lvl_exp[k/8-1], k/8);
        end
      end
    end
  endtask

  task automatic test_rate_change();
    int ticks[$];
    apply_reset();
    i_enable = 1'b1;
    for (int k = 0; k <= 82; k++) begin
      cyc();
      if (k == 9) i_sel = 2'd3;
      if (o_tick) ticks.push_back(k);
      n_chk++;
      if ({o_tick, o_level, o_busy, o_tick_count} !== {m_tick, m_level, m_run, m_count}) begin
        n_fail++;
        $display("FAIL rate_change_model E%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", k,
                 o_tick, o_level, o_busy, o_tick_count, m_tick, m_level, m_run, m_count);
      end
    end
    n_chk++;
    if (ticks.size() != 3 || ticks[0] != 64 || ticks[1] != 72 || ticks[2] != 80) begin
      n_fail++;
      $display("FAIL rate_change_edges: got %0d ticks first at E%0d, want E64,E72,E80",
               ticks.size(), (ticks.size() > 0) ? ticks[0] : -1);
    end
  endtask

  task automatic test_oneshot();
    int nt;
    apply_reset();
    i_mode = 2'b11; i_period = 16'd4; i_enable = 1'b1;
    for (int k = 0; k <= 5; k++) cyc();
    n_chk++;
    if (o_tick !== 1'b1 || o_busy !== 1'b0 || o_tick_count !== 8'd1) begin
      n_fail++;
      $display("FAIL oneshot_E5: got tick=%b busy=%b cnt=%0d want 1/0/1", o_tick, o_busy, o_tick_count);
    end
    nt = 0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (o_tick !== 1'b0 || o_busy !== 1'b0) nt++;
    end
    n_chk++;
    if (nt != 0 || o_tick_count !== 8'd1) begin
      n_fail++;
      $display("FAIL oneshot_quiet: got %0d active cycles cnt=%0d want 0 and 1", nt, o_tick_count);
    end
    i_enable = 1'b0;
    cyc();
    i_enable = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      cyc();
      n_chk++;
      if (o_tick !== (k == 5) || o_tick !== m_tick || o_busy !== m_run) begin
        n_fail++;
        $display("FAIL oneshot_rearm E%0d: got tick=%b busy=%b want tick=%b busy=%b", k,
                 o_tick, o_busy, (k == 5), m_run);
      end
    end
  endtask

  task automatic test_period_zero();
    int bad;
    apply_reset();
    i_mode = 2'b10; i_period = '0; i_enable = 1'b1;
    bad = 0;
    for (int k = 0; k <= 256; k++) begin
      cyc();
      if (o_tick !== (k >= 1) || o_level !== k[0] || o_tick !== m_tick) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL period_zero_stream: got %0d bad cycles want 0", bad);
    end
    n_chk++;
    if (o_tick_count !== 8'd0 || o_level !== 1'b0) begin
      n_fail++;
      $display("FAIL period_zero_wrap: got cnt=%0d lvl=%b want 0/0", o_tick_count, o_level);
    end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    i_enable = 1'b1;
    for (int k = 0; k <= 84; k++) cyc();
    i_enable = 1'b0;
    cyc();
    n_chk++;
    if ({o_tick, o_busy, o_level, o_tick_count} !== {1'b0, 1'b0, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL enable_drop: got tick=%b busy=%b lvl=%b cnt=%0d want 0/0/1/1",
               o_tick, o_busy, o_level, o_tick_count);
    end
    repeat (3) cyc();
    i_enable = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      cyc();
      n_chk++;
      if (o_tick !== (k == 64) || o_tick !== m_tick || o_tick_count !== m_count) begin
        n_fail++;
        $display("FAIL reenable_period E%0d: got tick=%b cnt=%0d want tick=%b cnt=%0d", k,
                 o_tick, o_tick_count, (k == 64), m_count);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    i_sel = 2'd3; i_enable = 1'b1;
    for (int k = 0; k <= 12; k++) cyc();
    #2 i_reset = 1'b1;
    #1;
    n_chk++;
    if ({o_tick, o_level, o_busy, o_tick_count} !== 11'b0) begin
      n_fail++;
      $display("FAIL async_reset: got tick=%b lvl=%b busy=%b cnt=%0d want all 0",
               o_tick, o_level, o_busy, o_tick_count);
    end
    model_reset();
    repeat (2) @(negedge clock);
    i_reset = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      cyc();
      n_chk++;
      if (o_tick !== (k == 8) || o_busy !== 1'b1 || o_tick !== m_tick) begin
        n_fail++;
        $display("FAIL post_reset E%0d: got tick=%b busy=%b want tick=%b busy=1", k,
                 o_tick, o_busy, (k == 8));
      end
    end
  endtask

  task automatic test_random();
    int bad;
    apply_reset();
    bad = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) i_enable = ~i_enable;
      if ($urandom_range(0, 7)  == 0) i_sel    = NB_SEL'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) i_mode   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7)  == 0) i_period = 16'($urandom_range(0, 12));
      cyc();
      if ({o_tick, o_level, o_busy, o_tick_count} !== {m_tick, m_level, m_run, m_count}) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random_model cyc %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", k,
                   o_tick, o_level, o_busy, o_tick_count, m_tick, m_level, m_run, m_count);
      end
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL random_total: got %0d mismatching cycles want 0", bad);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b0; i_sel = '0; i_mode = '0; i_period = '0;
    test_reset();
    test_first_ticks();
    test_rate_change();
    test_oneshot();
    test_period_zero();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
